// File: rtl/runway_pkg.sv
// runway_pkg
// Shared definitions for the runway allocator slice.
//   RUNWAY_ANY / RUNWAY_SPECIFIC : encoding of the "any runway" request bit
//   rwWidth()                    : runway index width, at least 1 bit
//   entryWidth()                 : width of a wait-queue entry laid out as
//                                  {id, any, runway}, id in the MSBs
package runway_pkg;

  typedef enum logic {
    RUNWAY_SPECIFIC = 1'b0,
    RUNWAY_ANY      = 1'b1
  } runwaySel_e;

  function automatic int rwWidth(input int nRunways);
    return (nRunways > 1) ? $clog2(nRunways) : 1;
  endfunction

  function automatic int entryWidth(input int idW, input int nRunways);
    return idW + 1 + rwWidth(nRunways);
  endfunction

endpackage

// File: rtl/runway_timer.sv
// runway_timer
// Occupancy timer for one runway. A load starts a HOLD_CYCLES countdown and
// raises busy; busy drops at the edge where the count reaches zero, so it is
// high for exactly HOLD_CYCLES enabled cycles. Everything freezes while en=0.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   en   : global enable
//   load : start a new occupancy (only issued while the runway is free)
//   busy : registered occupied flag
module runway_timer
  import runway_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic busy
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          busy_q, busy_d;

  // Next count: reload on a grant, otherwise count down and park at zero.
  // busy follows the next count so it clears on the same edge the count
  // hits zero.
  always_comb begin
    timer_d = timer_q;
    if (en) begin
      if (load) begin
        timer_d = TW'(HOLD_CYCLES);
      end else if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end
    end
    busy_d = (timer_d != '0);
  end

  // Count and busy flag registers; reset discards any occupancy at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/runway_allocator.sv
// runway_allocator
// Grants landing/take-off requests to one of N_RUNWAYS runways, holds each
// granted runway busy for HOLD_CYCLES, and parks requests that cannot be
// served in a strict-FIFO wait queue of QUEUE_DEPTH entries.
// Optional feature macro: RUNWAY_EMERGENCY_EN adds req_emerg; emergency
// requests bypass the queue and stall (req_ready=0) when no runway fits.
//   clk, rst          : clock (rising edge), async active-high reset
//   en                : global enable, freezes the block when low
//   req_valid/ready   : request handshake
//   req_id            : flight ID
//   req_any           : 1 = any runway, 0 = req_runway only
//   req_runway        : requested runway index
//   req_emerg         : emergency request (RUNWAY_EMERGENCY_EN only)
//   grant_valid/id/runway : one-cycle grant pulse and its payload
//   busy              : per-runway occupied flags
//   waiting           : queue non-empty
//   queue_count       : queue occupancy
//   overflow          : sticky, set by an accepted non-existent runway
module runway_allocator
  import runway_pkg::*;
#(
  parameter int N_RUNWAYS   = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter int ID_W        = 4,
  localparam int RW_W       = rwWidth(N_RUNWAYS),
  localparam int CW         = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ID_W-1:0]      req_id,
  input  logic                 req_any,
  input  logic [RW_W-1:0]      req_runway,
`ifdef RUNWAY_EMERGENCY_EN
  input  logic                 req_emerg,
`endif
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [RW_W-1:0]      grant_runway,
  output logic [N_RUNWAYS-1:0] busy,
  output logic                 waiting,
  output logic [CW-1:0]        queue_count,
  output logic                 overflow
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int EW = entryWidth(ID_W, N_RUNWAYS);

  logic [EW-1:0]        queue_q [QUEUE_DEPTH];
  logic [PW-1:0]        rdPtr_q, wrPtr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 waiting_q;
  logic                 grantValid_q;
  logic [ID_W-1:0]      grantId_q;
  logic [RW_W-1:0]      grantRunway_q;
  logic                 overflow_q;

  logic [N_RUNWAYS-1:0] busyVec;
  logic [N_RUNWAYS-1:0] loadVec;
  logic [ID_W-1:0]      headId;
  logic                 headAny;
  logic [RW_W-1:0]      headRw;
  logic                 headFound, newFound;
  logic [RW_W-1:0]      headPick, newPick;
  logic                 queueEmpty, queueFull;
  logic                 accept, emergGrant, overflowSet;
  logic                 grantFire, push, pop;
  logic [ID_W-1:0]      grantId;
  logic [RW_W-1:0]      grantRw;

  // Lowest-index free runway matching the request; an index past the last
  // runway never matches, so such a request can only wait.
  function automatic logic [RW_W:0] pickRunway(input logic anyBit,
                                               input logic [RW_W-1:0] rw,
                                               input logic [N_RUNWAYS-1:0] busyV);
    logic          found;
    logic [RW_W-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_RUNWAYS; i++) begin
      if (!found && !busyV[i] &&
          (runwaySel_e'(anyBit) == RUNWAY_ANY || rw == RW_W'(i))) begin
        found = 1'b1;
        pick  = RW_W'(i);
      end
    end
    return {found, pick};
  endfunction

  assign {headId, headAny, headRw} = queue_q[rdPtr_q];

  // Handshake and eligibility. Ready looks only at the registered count, so
  // a pop in this cycle never makes room for a push in the same cycle.
  always_comb begin
    queueEmpty             = (count_q == '0);
    queueFull              = (count_q == CW'(QUEUE_DEPTH));
    {headFound, headPick}  = pickRunway(headAny, headRw, busyVec);
    {newFound, newPick}    = pickRunway(req_any, req_runway, busyVec);
`ifdef RUNWAY_EMERGENCY_EN
    req_ready  = en && (req_emerg ? newFound : !queueFull);
    accept     = req_valid && req_ready;
    emergGrant = accept && req_emerg;
`else
    req_ready  = en && !queueFull;
    accept     = req_valid && req_ready;
    emergGrant = 1'b0;
`endif
    overflowSet = accept && !req_any && (32'(req_runway) >= N_RUNWAYS);
  end

  // Single grant per cycle: emergency first, then the queue head, then a new
  // request only when nothing is queued. Anything accepted but not granted
  // goes to the tail, which keeps arrival order even behind a blocked head.
  always_comb begin
    grantFire = 1'b0;
    grantId   = '0;
    grantRw   = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (en) begin
      if (emergGrant) begin
        grantFire = 1'b1;
        grantId   = req_id;
        grantRw   = newPick;
      end else if (!queueEmpty && headFound) begin
        grantFire = 1'b1;
        grantId   = headId;
        grantRw   = headPick;
        pop       = 1'b1;
        push      = accept;
      end else if (queueEmpty && accept && newFound) begin
        grantFire = 1'b1;
        grantId   = req_id;
        grantRw   = newPick;
      end else begin
        push      = accept;
      end
    end
    count_d = count_q + CW'(push) - CW'(pop);
    for (int r = 0; r < N_RUNWAYS; r++) begin
      loadVec[r] = grantFire && (grantRw == RW_W'(r));
    end
  end

  // One occupancy timer per runway.
  for (genvar r = 0; r < N_RUNWAYS; r++) begin : gTimer
    runway_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) uTimer (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .load (loadVec[r]),
      .busy (busyVec[r])
    );
  end

  // Queue storage, pointers and all output registers. Pointers wrap
  // naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      waiting_q     <= 1'b0;
      grantValid_q  <= 1'b0;
      grantId_q     <= '0;
      grantRunway_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (push) begin
        queue_q[wrPtr_q] <= {req_id, req_any, req_runway};
        wrPtr_q          <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      count_q      <= count_d;
      waiting_q    <= (count_d != '0);
      grantValid_q <= grantFire;
      if (grantFire) begin
        grantId_q     <= grantId;
        grantRunway_q <= grantRw;
      end
      overflow_q <= overflow_q | overflowSet;
    end
  end

  assign grant_valid  = grantValid_q;
  assign grant_id     = grantId_q;
  assign grant_runway = grantRunway_q;
  assign busy         = busyVec;
  assign waiting      = waiting_q;
  assign queue_count  = count_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/runway_allocator.md
# runway_allocator

Parametrised multi-runway allocator for the air-traffic-control datapath. Accepts landing/take-off requests through a valid/ready handshake, grants each to a free runway (a specific one or any), holds that runway busy for a fixed occupancy time, and queues requests that cannot be served in strict arrival order. It sits between the request decoder and the runway status indicators, and generalises the single-slot fixed-code runway status block to N runways with queuing.

## Interface
- N_RUNWAYS, 2: number of runways. Range is 1..8.
- HOLD_CYCLES, 16: cycles a granted runway stays busy. Must be ≥1.
- QUEUE_DEPTH, 4: wait-queue entries. Must be a power of two, ≥2.
- ID_W, 4: flight ID width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. When low, the block freezes.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_id  in  ID_W  flight ID.
- req_any  in  1  1 means any runway; 0 means runway req_runway only.
- req_runway  in  RW_W=max(1,$clog2(N_RUNWAYS))  requested runway. Ignored when req_any=1.
- grant_valid  out  1  one-cycle pulse for each grant.
- grant_id  out  ID_W  ID of the granted flight.
- grant_runway  out  RW_W  runway assigned to the granted flight.
- busy  out  N_RUNWAYS  per-runway occupied flag.
- waiting  out  1  queue non-empty.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current queue occupancy.
- overflow  out  1  sticky error flag; cleared only by rst.

## Operation
- **Reset values:** every output is 0, all timers are 0, and the queue is empty.
- **Eligibility:** a request is eligible on runway r if busy[r]==0 at the start of the cycle, and either req_any=1 or req_runway==r.
  - With req_any=1, the block picks the lowest-index free runway.
  - A req_runway value ≥ N_RUNWAYS is never eligible. If accepted it is enqueued and sets overflow.
- **Ready:** req_ready = en && queue not full, evaluated on the registered count.
  - A pop in the same cycle does not free a slot for a push.
- **One grant per cycle.** Priority order:
  1. Queue head, if eligible.
  2. Accepted new request, if the queue is empty and the request is eligible.
  3. Otherwise, an accepted new request is pushed to the queue tail.
- **No bypass:** while the queue is non-empty, new requests are always enqueued, preserving arrival order.
  - Head-of-line blocking is intended: a queue head waiting for runway 1 blocks a later request for runway 0.
- **Grant effects, registered at the granting edge:**
  - grant_valid=1 with grant_id and grant_runway set.
  - busy[r]=1.
  - The runway r timer is loaded with HOLD_CYCLES.
- **Timers:**
  - Each busy runway's timer decrements by 1 per en=1 cycle.
  - At the edge where the timer reaches 0, busy[r] clears.
  - busy[r] is therefore high for exactly HOLD_CYCLES enabled cycles.
  - The runway is re-grantable from the following cycle, so there is a minimum gap of one cycle with busy low.
- **Timer width:** $clog2(HOLD_CYCLES+1). The timer never wraps; a timer at 0 stays at 0.
- **en=0:**
  - Timers, queue and grants all freeze.
  - req_ready=0.
  - grant_valid=0.
  - busy holds its value.
- **Reset mid-operation:** all occupancy and queued requests are discarded immediately.

## Timing
- Grant latency is 1 cycle: a request accepted at edge k on a free runway gives grant_valid and busy high after edge k.
- A queued request is granted at the first edge where its runway is seen free. This is at earliest 1 cycle after the blocking runway's busy falls.
- grant_valid never stays high for 2 consecutive cycles for the same request.
- waiting and queue_count are registered and reflect the state after each edge.

## Configuration
- **RUNWAY_EMERGENCY_EN defined:**
  - Adds input req_emerg (1 bit).
  - An emergency request takes priority over the queue head and bypasses the queue.
  - If no eligible runway is free, req_ready=0 for it, so it stalls and is never enqueued. In this mode req_ready is combinationally dependent on req_emerg, req_any and req_runway.
- **RUNWAY_EMERGENCY_EN undefined:**
  - The req_emerg port is absent.
  - All requests follow FIFO ordering.

## Structure
- **Package runway_pkg:**
  - RW_W computation function.
  - Queue entry layout {id, any, runway}.
  - RUNWAY_ANY encoding constant.
- **Sub-module runway_timer:**
  - Load/decrement/expire counter producing busy.
  - Instantiated N_RUNWAYS times.
- **Top level:** queue (circular buffer with read/write pointers and count), eligibility/priority logic, and output registers.

## Test plan
- **Reset mid-hold.** Defaults. Grant runway 0, assert rst at cycle 5, then release → busy=0, queue_count=0, and a new request is granted with 1-cycle latency.
- **Basic hold.** Defaults. Single request id=3, req_any=1 → next cycle grant_valid=1, grant_runway=0. busy[0] stays high exactly 16 cycles.
- **Order preservation.** Occupy both runways, then send ids 5,6,7 with any → queue_count=3. Grants appear in order 5,6,7 as runways free, each 1 cycle after busy falls.
- **Full queue.** Fill the queue to 4 entries → req_ready=0. A simultaneous pop and a new valid request → the request is not accepted that cycle.
- **Freeze.** Hold en=0 for 10 cycles mid-occupancy → the timer is unchanged and busy stays high. After en returns, busy still totals 16 enabled cycles.
- **Emergency bypass (with RUNWAY_EMERGENCY_EN).** Queue non-empty with head waiting on runway 1; emergency request for runway 0, which is free → granted next cycle ahead of the queue.
